// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller and its MDU sequencer.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

    // The youngest in-flight writer wins, so MEM is tested before WB.
    function automatic logic [1:0] fwd_sel(input logic       mem_we,
                                           input logic [4:0] mem_rd,
                                           input logic       wb_we,
                                           input logic [4:0] wb_rd,
                                           input logic [4:0] src);
        if (mem_we && mem_rd != 5'd0 && mem_rd == src)
            return FWD_MEM;
        else if (wb_we && wb_rd != 5'd0 && wb_rd == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Tracks one multiply/divide op from start to HI/LO commit; busy spans BUSY and DONE.
module mdu_sequencer
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic div_i,
    input  logic redirect_i,
    output logic busy_o,
    output logic done_o
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    mdu_state_e state_q;
    logic [5:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [5:0] load_d;
    logic       accept_d;

    assign load_d   = div_i ? DIV_LOAD : MUL_LOAD;
    assign accept_d = start_i & ~redirect_i;

    // A load of 1 (two-cycle op) skips BUSY so DONE still lands at start+CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_d) begin
                        cnt_q   <= load_d;
                        state_q <= (load_d == 6'd1) ? DONE : BUSY;
                        busy_q  <= 1'b1;
                        done_q  <= (load_d == 6'd1);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_q  <= cnt_q - 6'd1;
                    busy_q <= 1'b1;
                    if (cnt_q == 6'd2) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline, with MDU tracking and a halt latch.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       ID_UseHiLo,
    input  logic [4:0] EX_Rs,
    input  logic [4:0] EX_Rt,
    input  logic [4:0] EX_WbRegNum,
    input  logic       EX_RegWrite,
    input  logic       EX_MemtoReg,
    input  logic       EX_Redirect,
    input  logic       EX_MduStart,
    input  logic       EX_MduDiv,
    input  logic       EX_Syscall,
    input  logic [4:0] MEM_WbRegNum,
    input  logic       MEM_RegWrite,
    input  logic [4:0] WB_WbRegNum,
    input  logic       WB_RegWrite,
    output logic       PC_En,
    output logic       IFID_En,
    output logic       IFID_CLR,
    output logic       IDEX_CLR,
    output logic       EXMEM_CLR,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       MduBusy,
    output logic       MduDone,
    output logic       Halted
);

    logic load_use;
    logic hilo_wait;
    logic halt_q;

    mdu_sequencer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .start_i   (EX_MduStart),
        .div_i     (EX_MduDiv),
        .redirect_i(EX_Redirect),
        .busy_o    (MduBusy),
        .done_o    (MduDone)
    );

    assign load_use = EX_RegWrite & EX_MemtoReg & (EX_WbRegNum != 5'd0) &
                      ((ID_UseRs & (ID_Rs == EX_WbRegNum)) |
                       (ID_UseRt & (ID_Rt == EX_WbRegNum)));

    // A start still in EX counts as busy so the HI/LO reader never slips in behind it.
    assign hilo_wait = ID_UseHiLo & (MduBusy | EX_MduStart);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halt_q <= 1'b0;
        else if (EX_Syscall & ~EX_Redirect)
            halt_q <= 1'b1;
    end

    assign Halted = halt_q;

    always_comb begin
        PC_En     = 1'b1;
        IFID_En   = 1'b1;
        IFID_CLR  = 1'b0;
        IDEX_CLR  = 1'b0;
        EXMEM_CLR = 1'b0;
        if (rst) begin
            PC_En     = 1'b0;
            IFID_En   = 1'b0;
            IFID_CLR  = 1'b1;
            IDEX_CLR  = 1'b1;
            EXMEM_CLR = 1'b1;
        end else if (halt_q) begin
            PC_En    = 1'b0;
            IFID_En  = 1'b0;
            IDEX_CLR = 1'b1;
        end else if (EX_Redirect) begin
            IFID_CLR = 1'b1;
            IDEX_CLR = 1'b1;
        end else if (load_use | hilo_wait) begin
            PC_En    = 1'b0;
            IFID_En  = 1'b0;
            IDEX_CLR = 1'b1;
        end
    end

    always_comb begin
        ForwardA = FWD_RF;
        ForwardB = FWD_RF;
        if (!rst) begin
            ForwardA = fwd_sel(MEM_RegWrite, MEM_WbRegNum, WB_RegWrite, WB_WbRegNum, EX_Rs);
            ForwardB = fwd_sel(MEM_RegWrite, MEM_WbRegNum, WB_RegWrite, WB_WbRegNum, EX_Rt);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: expected output vectors are queued as stimulus is driven.
module tb_pipeline_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WbRegNum, MEM_WbRegNum, WB_WbRegNum;
    logic       ID_UseRs, ID_UseRt, ID_UseHiLo;
    logic       EX_RegWrite, EX_MemtoReg, EX_Redirect, EX_MduStart, EX_MduDiv, EX_Syscall;
    logic       MEM_RegWrite, WB_RegWrite;
    logic       PC_En, IFID_En, IFID_CLR, IDEX_CLR, EXMEM_CLR, MduBusy, MduDone, Halted;
    logic [1:0] ForwardA, ForwardB;

    int total = 0;
    int bad   = 0;
    logic [11:0] sb[$];

    pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_UseHiLo(ID_UseHiLo),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WbRegNum(EX_WbRegNum),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_Redirect(EX_Redirect),
        .EX_MduStart(EX_MduStart), .EX_MduDiv(EX_MduDiv), .EX_Syscall(EX_Syscall),
        .MEM_WbRegNum(MEM_WbRegNum), .MEM_RegWrite(MEM_RegWrite),
        .WB_WbRegNum(WB_WbRegNum), .WB_RegWrite(WB_RegWrite),
        .PC_En(PC_En), .IFID_En(IFID_En), .IFID_CLR(IFID_CLR), .IDEX_CLR(IDEX_CLR),
        .EXMEM_CLR(EXMEM_CLR), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MduBusy(MduBusy), .MduDone(MduDone), .Halted(Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: pc ifen ifclr idclr exclr fa[2] fb[2] busy done halt
    function automatic logic [11:0] mk(input logic pc, input logic ife, input logic ifc,
                                       input logic idc, input logic exc,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic bz, input logic dn, input logic hl);
        return {pc, ife, ifc, idc, exc, fa, fb, bz, dn, hl};
    endfunction

    function automatic logic [11:0] obs();
        return {PC_En, IFID_En, IFID_CLR, IDEX_CLR, EXMEM_CLR, ForwardA, ForwardB,
                MduBusy, MduDone, Halted};
    endfunction

    task automatic drive_idle();
        ID_Rs = 0; ID_Rt = 0; ID_UseRs = 0; ID_UseRt = 0; ID_UseHiLo = 0;
        EX_Rs = 0; EX_Rt = 0; EX_WbRegNum = 0; EX_RegWrite = 0; EX_MemtoReg = 0;
        EX_Redirect = 0; EX_MduStart = 0; EX_MduDiv = 0; EX_Syscall = 0;
        MEM_WbRegNum = 0; MEM_RegWrite = 0; WB_WbRegNum = 0; WB_RegWrite = 0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        for (int t = 0; t < 2; t++) begin
            drive_idle();
            EX_Rs = 5; MEM_WbRegNum = 5; MEM_RegWrite = 1; EX_Rt = 6; WB_WbRegNum = 6; WB_RegWrite = 1;
            sb.push_back(mk(0, 0, 1, 1, 1, 2'b00, 2'b00, 0, 0, 0));
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL reset t=%0d got=%b exp=%b", t, obs(), e); end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [11:0] e;
        for (int t = 0; t < 6; t++) begin
            drive_idle();
            case (t)
                0: begin EX_RegWrite = 1; EX_MemtoReg = 1; EX_WbRegNum = 2;
                         ID_Rs = 2; ID_UseRs = 1; ID_Rt = 4; ID_UseRt = 1;
                         sb.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); end
                1: begin MEM_RegWrite = 1; MEM_WbRegNum = 2; ID_Rs = 2; ID_UseRs = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); end
                2: begin EX_RegWrite = 1; EX_MemtoReg = 1; EX_WbRegNum = 0;
                         ID_Rs = 0; ID_UseRs = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); end
                3: begin EX_RegWrite = 1; EX_MemtoReg = 1; EX_WbRegNum = 7;
                         ID_Rt = 7; ID_UseRt = 1;
                         sb.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); end
                4: begin EX_RegWrite = 1; EX_MemtoReg = 1; EX_WbRegNum = 7; ID_Rs = 7; ID_Rt = 7;
                         sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); end
                default: begin EX_RegWrite = 1; EX_WbRegNum = 7; ID_Rs = 7; ID_UseRs = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); end
            endcase
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL load_use t=%0d got=%b exp=%b", t, obs(), e); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic [11:0] e;
        for (int t = 0; t < 3; t++) begin
            drive_idle();
            if (t == 0) begin
                EX_RegWrite = 1; EX_MemtoReg = 1; EX_WbRegNum = 2; ID_Rs = 2; ID_UseRs = 1;
                EX_Redirect = 1; EX_Syscall = 1; EX_MduStart = 1; ID_UseHiLo = 1;
                sb.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
            end else begin
                sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL redirect t=%0d got=%b exp=%b", t, obs(), e); end
            @(negedge clk);
        end
    endtask

    task automatic test_forward();
        logic [11:0] e;
        for (int t = 0; t < 4; t++) begin
            drive_idle();
            case (t)
                0: begin EX_Rs = 5; MEM_WbRegNum = 5; MEM_RegWrite = 1; WB_WbRegNum = 5; WB_RegWrite = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0)); end
                1: begin EX_Rs = 5; MEM_WbRegNum = 5; MEM_RegWrite = 0; WB_WbRegNum = 5; WB_RegWrite = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0)); end
                2: begin EX_Rs = 0; MEM_WbRegNum = 0; MEM_RegWrite = 1; WB_WbRegNum = 0; WB_RegWrite = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0)); end
                default: begin EX_Rs = 5; EX_Rt = 9; MEM_WbRegNum = 9; MEM_RegWrite = 1;
                         WB_WbRegNum = 5; WB_RegWrite = 1;
                         sb.push_back(mk(1, 1, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0)); end
            endcase
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL forward t=%0d got=%b exp=%b", t, obs(), e); end
            @(negedge clk);
        end
    endtask

    // Divide with mflo waiting in ID: start at t=0, busy 1..31, done 31, stall 0..31.
    task automatic test_mdu_div();
        logic [11:0] e;
        logic bz, dn, st;
        for (int t = 0; t <= 34; t++) begin
            drive_idle();
            ID_UseHiLo  = (t <= 32);
            EX_MduStart = (t == 0);
            EX_MduDiv   = (t == 0);
            bz = (t >= 1 && t <= 31);
            dn = (t == 31);
            st = (t <= 31);
            sb.push_back(st ? mk(0, 0, 0, 1, 0, 0, 0, bz, dn, 0) : mk(1, 1, 0, 0, 0, 0, 0, bz, dn, 0));
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL mdu_div t=%0d got=%b exp=%b", t, obs(), e); end
            @(negedge clk);
        end
    endtask

    // Multiply at t=0, stray start at t=1 (ignored), back-to-back start in DONE at t=3.
    task automatic test_back_to_back();
        logic [11:0] e;
        logic bz, dn;
        for (int t = 0; t <= 8; t++) begin
            drive_idle();
            EX_MduStart = (t == 0 || t == 1 || t == 3);
            bz = (t >= 1 && t <= 6);
            dn = (t == 3 || t == 6);
            sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, bz, dn, 0));
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL back_to_back t=%0d got=%b exp=%b", t, obs(), e); end
            @(negedge clk);
        end
    endtask

    // Syscall at t=0, halted from t=1; divide started at t=3 is cut by reset at its count 7 (t=28).
    task automatic test_halt_reset();
        logic [11:0] e;
        logic bz;
        for (int t = 0; t <= 40; t++) begin
            drive_idle();
            rst = (t == 29);
            EX_Syscall  = (t == 0);
            EX_MduStart = (t == 3);
            EX_MduDiv   = (t == 3);
            if (t == 2) begin
                EX_Redirect = 1; EX_RegWrite = 1; EX_MemtoReg = 1; EX_WbRegNum = 3;
                ID_Rs = 3; ID_UseRs = 1;
            end
            bz = (t >= 4 && t <= 28);
            if (t == 0)
                sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            else if (t <= 28)
                sb.push_back(mk(0, 0, 0, 1, 0, 0, 0, bz, 0, 1));
            else if (t == 29)
                sb.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
            else
                sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            #2;
            e = sb.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL halt t=%0d got=%b exp=%b", t, obs(), e); end
            if (t == 28) begin
                rst = 1'b1;
                sb.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
                #1;
                e = sb.pop_front(); total++;
                if (obs() !== e) begin bad++; $display("FAIL async_reset got=%b exp=%b", obs(), e); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_forward();
        test_mdu_div();
        test_back_to_back();
        test_halt_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
